// File: rtl/bsr_ctrl_pkg.sv
// Shared state encoding, counter sizing and per-state output decode for the boundary-scan controller.
package bsr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        CAPTURE,
        UNLOAD,
        DONE
    } bsr_state_e;

    typedef struct packed {
        logic cmd_ready;
        logic busy;
        logic shift;
        logic testing;
        logic rsp_valid;
        logic drive_sin;
    } bsr_out_t;

    localparam bsr_out_t OUT_IDLE    = '{cmd_ready: 1'b1, busy: 1'b0, shift: 1'b0, testing: 1'b0, rsp_valid: 1'b0, drive_sin: 1'b0};
    localparam bsr_out_t OUT_LOAD    = '{cmd_ready: 1'b0, busy: 1'b1, shift: 1'b1, testing: 1'b0, rsp_valid: 1'b0, drive_sin: 1'b1};
    localparam bsr_out_t OUT_APPLY   = '{cmd_ready: 1'b0, busy: 1'b1, shift: 1'b0, testing: 1'b1, rsp_valid: 1'b0, drive_sin: 1'b0};
    localparam bsr_out_t OUT_CAPTURE = '{cmd_ready: 1'b0, busy: 1'b1, shift: 1'b0, testing: 1'b1, rsp_valid: 1'b0, drive_sin: 1'b0};
    localparam bsr_out_t OUT_UNLOAD  = '{cmd_ready: 1'b0, busy: 1'b1, shift: 1'b1, testing: 1'b0, rsp_valid: 1'b0, drive_sin: 1'b0};
    localparam bsr_out_t OUT_DONE    = '{cmd_ready: 1'b0, busy: 1'b1, shift: 1'b0, testing: 1'b0, rsp_valid: 1'b1, drive_sin: 1'b0};

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bsr_out_t decode_outputs(input bsr_state_e s);
        case (s)
            IDLE:    return OUT_IDLE;
            LOAD:    return OUT_LOAD;
            APPLY:   return OUT_APPLY;
            CAPTURE: return OUT_CAPTURE;
            UNLOAD:  return OUT_UNLOAD;
            DONE:    return OUT_DONE;
            default: return OUT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bsr_scan_serdes.sv
// Stimulus PISO and response SIPO for one scan chain, both addressed by the controller's bit counter.
module bsr_scan_serdes
    import bsr_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int CW        = cnt_width(CHAIN_LEN)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic [CW-1:0]        sin_idx,
    output logic                 sin_bit,
    input  logic                 cap_en,
    input  logic [CW-1:0]        cap_idx,
    input  logic                 cap_bit,
    output logic [CHAIN_LEN-1:0] rsp_data
);

    logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
    logic [CHAIN_LEN-1:0] rsp_q, rsp_d;

    // On the accept cycle the pattern register is still stale, so bit 0 comes straight from load_data.
    always_comb begin
        pattern_d = load_en ? load_data : pattern_q;
        rsp_d     = rsp_q;
        sin_bit   = 1'b0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (sin_idx == CW'(i)) begin
                sin_bit = pattern_d[i];
            end
            if (cap_en && (cap_idx == CW'(i))) begin
                rsp_d[i] = cap_bit;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pattern_q <= '0;
            rsp_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            rsp_q     <= rsp_d;
        end
    end

    assign rsp_data = rsp_q;

endmodule

// File: rtl/bsr_scan_controller.sv
// Boundary-scan chain controller: shift stimulus in, apply, capture, shift response out, hand it back.
// Defining BSR_CHECK_EN adds cmd_expect/cmd_mask inputs and a masked rsp_mismatch flag.
module bsr_scan_controller
    import bsr_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN   = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHAIN_LEN-1:0] cmd_pattern,
`ifdef BSR_CHECK_EN
    input  logic [CHAIN_LEN-1:0] cmd_expect,
    input  logic [CHAIN_LEN-1:0] cmd_mask,
    output logic                 rsp_mismatch,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 busy,
    output logic                 bsr_shift,
    output logic                 bsr_testing,
    output logic                 bsr_sin,
    input  logic                 bsr_sout
);

    localparam int CW = cnt_width(CHAIN_LEN);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    bsr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    bsr_out_t      out_q, out_d;
    logic          sin_q, sin_d;
    logic          pattern_bit;
    logic          accept;

    assign accept = cmd_valid & out_q.cmd_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            sin_q   <= sin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = APPLY;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            CAPTURE: begin
                state_d = UNLOAD;
                cnt_d   = '0;
            end
            UNLOAD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet valid in the state's first cycle.
    always_comb begin
        out_d = decode_outputs(state_d);
        sin_d = out_d.drive_sin & pattern_bit;
    end

    bsr_scan_serdes #(
        .CHAIN_LEN (CHAIN_LEN),
        .CW        (CW)
    ) u_serdes (
        .clock     (clock),
        .reset     (reset),
        .load_en   (accept),
        .load_data (cmd_pattern),
        .sin_idx   (cnt_d),
        .sin_bit   (pattern_bit),
        .cap_en    (state_q == UNLOAD),
        .cap_idx   (cnt_q),
        .cap_bit   (bsr_sout),
        .rsp_data  (rsp_data)
    );

    assign cmd_ready   = out_q.cmd_ready;
    assign busy        = out_q.busy;
    assign bsr_shift   = out_q.shift;
    assign bsr_testing = out_q.testing;
    assign rsp_valid   = out_q.rsp_valid;
    assign bsr_sin     = sin_q & out_q.drive_sin;

`ifdef BSR_CHECK_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            exp_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            exp_q  <= cmd_expect;
            mask_q <= cmd_mask;
        end
    end

    assign rsp_mismatch = out_q.rsp_valid & (|((rsp_data ^ exp_q) & mask_q));
`endif

endmodule

// File: tb/tb_bsr_scan_controller.sv
// Self-checking bench for bsr_scan_controller driving a behavioural 4-input/4-output BSR chain.
// Build with BSR_CHECK_EN defined to also exercise the masked response compare.
`timescale 1ns/1ps
module tb_bsr_scan_controller;

    localparam int LEN     = 8;
    localparam int HOLD    = 2;
    localparam int LATENCY = 2 * LEN + HOLD + 1;

    logic           clock       = 1'b0;
    logic           reset       = 1'b0;
    logic           cmd_valid   = 1'b0;
    logic           cmd_ready;
    logic [LEN-1:0] cmd_pattern = '0;
    logic           rsp_valid;
    logic           rsp_ready   = 1'b0;
    logic [LEN-1:0] rsp_data;
    logic           busy;
    logic           bsr_shift;
    logic           bsr_testing;
    logic           bsr_sin;
    logic           bsr_sout;
`ifdef BSR_CHECK_EN
    logic [LEN-1:0] cmd_expect  = '0;
    logic [LEN-1:0] cmd_mask    = '0;
    logic           rsp_mismatch;
`endif

    int             total       = 0;
    int             bad         = 0;
    logic           overlapSeen = 1'b0;
    logic [LEN-1:0] cells       = '0;
    logic [LEN-1:0] expQ[$];

    always #5 clock = ~clock;

    bsr_scan_controller #(
        .CHAIN_LEN   (LEN),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pattern  (cmd_pattern),
`ifdef BSR_CHECK_EN
        .cmd_expect   (cmd_expect),
        .cmd_mask     (cmd_mask),
        .rsp_mismatch (rsp_mismatch),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .bsr_shift    (bsr_shift),
        .bsr_testing  (bsr_testing),
        .bsr_sin      (bsr_sin),
        .bsr_sout     (bsr_sout)
    );

    // Cells 0..3 (nearest sin) are input cells; the core loops each to output cell 4..7 while testing.
    always @(posedge clock) begin
        if (bsr_shift) begin
            cells <= {cells[LEN-2:0], bsr_sin};
        end else if (bsr_testing) begin
            cells[7:4] <= cells[3:0];
        end
    end
    assign bsr_sout = cells[LEN-1];

    always @(negedge clock) begin
        if (reset && bsr_shift === 1'b1 && bsr_testing === 1'b1) begin
            overlapSeen = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pattern bit k ends in cell 7-k; output cell 4+j copies input cell j; response bit k reads cell 7-k.
    function automatic logic [LEN-1:0] chainModel(input logic [LEN-1:0] p);
        return {p[7:4], p[7:4]};
    endfunction

    function automatic logic [LEN-1:0] popExpected();
        if (expQ.size() == 0) begin
            return 'x;
        end
        return expQ.pop_front();
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [LEN-1:0] pat, output bit ok);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
            ok = 1'b0;
            return;
        end
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        expQ.push_back(chainModel(pat));
        step();
        cmd_valid = 1'b0;
        ok        = 1'b1;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic takeResponse();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) step();
        total++;
        if ({cmd_ready, rsp_valid, busy, bsr_shift, bsr_testing, bsr_sin, rsp_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b busy=%b shift=%b testing=%b sin=%b data=%h required all 0",
                     cmd_ready, rsp_valid, busy, bsr_shift, bsr_testing, bsr_sin, rsp_data);
        end
        reset = 1'b1;
        step();
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
        applyStimulus(8'h3C, ok);
        repeat (3) step();
        total++;
        if (busy !== 1'b1 || bsr_shift !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_load: busy=%b shift=%b required 1/1", busy, bsr_shift);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({cmd_ready, rsp_valid, busy, bsr_shift, bsr_testing, bsr_sin, rsp_data} !== '0) begin
                bad++;
                $display("[TB] FAIL midreset_outputs[%0d]: ready=%b busy=%b shift=%b testing=%b sin=%b data=%h required all 0",
                         i, cmd_ready, busy, bsr_shift, bsr_testing, bsr_sin, rsp_data);
            end
        end
        reset = 1'b1;
        step();
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_release: ready=%b busy=%b valid=%b required 1/0/0", cmd_ready, busy, rsp_valid);
        end
        expQ.delete();
    endtask

    task automatic test_pattern();
        bit             ok;
        int             n;
        int             testingCycles;
        bit             shiftOk;
        logic [LEN-1:0] sinSeq;
        logic [LEN-1:0] exp;
        applyStimulus(8'hA5, ok);
        n             = 0;
        testingCycles = 0;
        shiftOk       = 1'b1;
        sinSeq        = '0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            if (n < LEN) begin
                sinSeq[n] = bsr_sin;
                if (bsr_shift !== 1'b1 || bsr_testing !== 1'b0) shiftOk = 1'b0;
            end
            if (bsr_testing === 1'b1) testingCycles++;
            step();
            n++;
        end
        total++;
        if (n !== LATENCY) begin
            bad++;
            $display("[TB] FAIL latency: got %0d cycles required %0d", n, LATENCY);
        end
        total++;
        if (sinSeq !== 8'hA5 || !shiftOk) begin
            bad++;
            $display("[TB] FAIL sin_sequence: got %h shiftOk=%0d required a5 shiftOk=1", sinSeq, shiftOk);
        end
        total++;
        if (testingCycles !== HOLD + 1) begin
            bad++;
            $display("[TB] FAIL testing_cycles: got %0d required %0d", testingCycles, HOLD + 1);
        end
        exp = popExpected();
        total++;
        if (rsp_data !== exp) begin
            bad++;
            $display("[TB] FAIL pattern_a5_data: got %h required %h", rsp_data, exp);
        end
        takeResponse();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL after_take: valid=%b busy=%b ready=%b required 0/0/1", rsp_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_hold();
        bit             ok;
        int             n;
        logic [LEN-1:0] held;
        logic [LEN-1:0] exp;
        applyStimulus(8'h96, ok);
        waitValid(n);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== held) begin
                bad++;
                $display("[TB] FAIL hold_stable[%0d]: valid=%b data=%h required 1/%h", i, rsp_valid, rsp_data, held);
            end
        end
        exp = popExpected();
        total++;
        if (held !== exp) begin
            bad++;
            $display("[TB] FAIL hold_data: got %h required %h", held, exp);
        end
        takeResponse();
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_take: busy=%b valid=%b required 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_ignore();
        bit             ok;
        bit             ignoredOk;
        int             n;
        logic [LEN-1:0] exp;
        applyStimulus(8'h5A, ok);
        ignoredOk = 1'b1;
        n         = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            if (cmd_ready !== 1'b0) ignoredOk = 1'b0;
            cmd_valid   = (n < LATENCY - 2) ? n[0] : 1'b0;
            cmd_pattern = n[1] ? 8'hF0 : 8'h0F;
            rsp_ready   = (n < LATENCY - 2) ? n[1] : 1'b0;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (n !== LATENCY || !ignoredOk) begin
            bad++;
            $display("[TB] FAIL ignore_timing: got %0d cycles readyLow=%0d required %0d/1", n, ignoredOk, LATENCY);
        end
        exp = popExpected();
        total++;
        if (rsp_data !== exp) begin
            bad++;
            $display("[TB] FAIL ignore_data: got %h required %h", rsp_data, exp);
        end
        takeResponse();
        step();
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL ignore_no_extra: busy=%b valid=%b pending=%0d required 0/0/0", busy, rsp_valid, expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        int             cyc;
        int             accepts;
        int             takes;
        int             firstAcc;
        int             secondAcc;
        bit             readyOk;
        bit             acc;
        bit             take;
        logic [LEN-1:0] exp;
        cyc         = 0;
        accepts     = 0;
        takes       = 0;
        firstAcc    = -1;
        secondAcc   = -1;
        readyOk     = 1'b1;
        cmd_pattern = 8'hFF;
        cmd_valid   = 1'b1;
        rsp_ready   = 1'b1;
        while (takes < 2 && cyc < 200) begin
            acc  = cmd_valid && (cmd_ready === 1'b1);
            take = (rsp_valid === 1'b1) && rsp_ready;
            if (cmd_ready !== !busy) readyOk = 1'b0;
            if (take) begin
                exp = popExpected();
                total++;
                if (rsp_data !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_data[%0d]: got %h required %h", takes, rsp_data, exp);
                end
                takes++;
            end
            if (acc) begin
                expQ.push_back(chainModel(cmd_pattern));
                accepts++;
                if (accepts == 1) firstAcc = cyc;
                else secondAcc = cyc;
            end
            step();
            cyc++;
            if (acc) begin
                if (accepts == 1) cmd_pattern = 8'h00;
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (takes !== 2 || accepts !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_count: accepts=%0d responses=%0d required 2/2", accepts, takes);
        end
        total++;
        if (secondAcc - firstAcc !== LATENCY + 2) begin
            bad++;
            $display("[TB] FAIL b2b_gap: got %0d cycles required %0d", secondAcc - firstAcc, LATENCY + 2);
        end
        total++;
        if (!readyOk) begin
            bad++;
            $display("[TB] FAIL b2b_ready_vs_busy: readyOk=%0d required 1", readyOk);
        end
    endtask

`ifdef BSR_CHECK_EN
    task automatic test_check();
        bit             ok;
        int             n;
        logic [LEN-1:0] expv  [3];
        logic [LEN-1:0] maskv [3];
        logic           want  [3];
        logic [LEN-1:0] exp;
        expv[0]  = chainModel(8'hA5);
        expv[1]  = chainModel(8'hA5) ^ 8'h08;
        expv[2]  = chainModel(8'hA5) ^ 8'h08;
        maskv[0] = 8'hFF;
        maskv[1] = 8'hFF;
        maskv[2] = 8'hF7;
        want[0]  = 1'b0;
        want[1]  = 1'b1;
        want[2]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_expect = expv[i];
            cmd_mask   = maskv[i];
            applyStimulus(8'hA5, ok);
            cmd_expect = ~expv[i];
            cmd_mask   = 8'hFF;
            step();
            total++;
            if (rsp_mismatch !== 1'b0) begin
                bad++;
                $display("[TB] FAIL check_busy_flag[%0d]: got %b required 0", i, rsp_mismatch);
            end
            waitValid(n);
            total++;
            if (rsp_mismatch !== want[i]) begin
                bad++;
                $display("[TB] FAIL check_mismatch[%0d]: got %b required %b", i, rsp_mismatch, want[i]);
            end
            exp = popExpected();
            total++;
            if (rsp_data !== exp) begin
                bad++;
                $display("[TB] FAIL check_data[%0d]: got %h required %h", i, rsp_data, exp);
            end
            takeResponse();
            total++;
            if (rsp_mismatch !== 1'b0) begin
                bad++;
                $display("[TB] FAIL check_idle_flag[%0d]: got %b required 0", i, rsp_mismatch);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] starting bsr_scan_controller bench");
        test_reset();
        test_pattern();
        test_hold();
        test_ignore();
        test_back_to_back();
`ifdef BSR_CHECK_EN
        test_check();
`endif
        total++;
        if (overlapSeen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL shift_testing_overlap: got %b required 0", overlapSeen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
